// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the receiver and the transmitter-side logic:
// default clock/baud, bit-time derivation helpers, receiver FSM encoding and
// the note index constants used by the note mapping.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int CLK_FREQ_DEF  = 25_000_000;
   localparam int BAUD_RATE_DEF = 115_200;

   // Clock cycles per serial bit (integer division, truncates).
   function automatic int calc_bit_time(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Offset from the start-bit edge to the middle of the start bit.
   function automatic int calc_half(input int bit_time);
      return bit_time / 2;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } uart_state_t;

   localparam logic [2:0] NOTA_DO  = 3'd0;
   localparam logic [2:0] NOTA_MI  = 3'd2;
   localparam logic [2:0] NOTA_SOL = 3'd4;

endpackage

// File: rtl/sincronizador_2ff.sv
// ---------------------------------------------------------------------------
// sincronizador_2ff
// Two-flop synchronizer for a single asynchronous input. The reset value is a
// parameter so idle-high lines (UART RX) and idle-low inputs can share it.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous, active-high reset (both flops take RST_VAL)
//   i_d  - asynchronous input
//   o_q  - synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sincronizador_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_nota.sv
// ---------------------------------------------------------------------------
// uart_rx_nota
// 8N1 UART receiver with mid-bit sampling, framing-error detection and a
// one-stage note decoder (bytes 0..7 become a 3-bit note index).
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous, active-high reset
//   i_rx          - raw serial line, idle high, asynchronous to clk
//   o_rx_data     - last correctly framed byte
//   o_rx_valid    - one-cycle pulse when o_rx_data is updated
//   o_frame_err   - one-cycle pulse when the stop bit samples 0
//   o_busy        - high whenever the receiver FSM is not in IDLE
//   o_nota        - last valid note index
//   o_nota_valid  - one-cycle pulse, cycle after o_rx_valid, byte is a note
//   o_nota_err    - one-cycle pulse, cycle after o_rx_valid, byte >= 8
//   o_dbg_state   - current receiver FSM state encoding
// Pulse outputs carry no handshake: there is no ready, the consumer must
// capture o_rx_data/o_nota in the cycle the matching pulse is high.
// ---------------------------------------------------------------------------
module uart_rx_nota
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = CLK_FREQ_DEF,
   parameter int BAUD_RATE = BAUD_RATE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_frame_err,
   output logic       o_busy,
   output logic [2:0] o_nota,
   output logic       o_nota_valid,
   output logic       o_nota_err,
   output logic [2:0] o_dbg_state
);

   localparam int BIT_TIME = calc_bit_time(CLK_FREQ, BAUD_RATE);
   localparam int HALF     = calc_half(BIT_TIME);

   localparam logic [15:0] C_BIT_LAST  = 16'(BIT_TIME - 1);
   localparam logic [15:0] C_HALF_LAST = 16'(HALF - 1);
   localparam logic [2:0]  C_LAST_BIT  = 3'd7;

   if (BIT_TIME < 4) begin : g_bit_time_check
      $error("uart_rx_nota: BIT_TIME must be at least 4 clocks");
   end

   uart_state_t r_state;
   uart_state_t w_next_state;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic [7:0]  r_rx_data;
   logic        r_rx_valid;
   logic        r_frame_err;
   logic [2:0]  r_nota;
   logic        r_nota_valid;
   logic        r_nota_err;

   logic w_rx_s;
   logic w_half_end;
   logic w_bit_end;
   logic w_busy;
   logic w_shift_en;
   logic w_stop_ok;
   logic w_stop_bad;

   sincronizador_2ff #(.RST_VAL(1'b1)) u_sync_rx (
      .clk (clk),
      .rst (rst),
      .i_d (i_rx),
      .o_q (w_rx_s)
   );

   assign w_half_end = (r_cnt == C_HALF_LAST);
   assign w_bit_end  = (r_cnt == C_BIT_LAST);

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // FSM: next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:      if (!w_rx_s) w_next_state = ST_START;
         // A start bit that is high again at its middle is treated as noise.
         ST_START:     if (w_half_end) w_next_state = w_rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:      if (w_bit_end && (r_bit_idx == C_LAST_BIT)) w_next_state = ST_STOP;
         ST_STOP:      if (w_bit_end) w_next_state = w_rx_s ? ST_IDLE : ST_WAIT_IDLE;
         // A held-low line must go high before another frame is hunted,
         // so a break reports a single framing error.
         ST_WAIT_IDLE: if (w_rx_s) w_next_state = ST_IDLE;
         default:      w_next_state = ST_IDLE;
      endcase
   end

   // FSM: outputs / strobes
   always_comb begin
      w_busy     = (r_state != ST_IDLE);
      w_shift_en = (r_state == ST_DATA) && w_bit_end;
      w_stop_ok  = (r_state == ST_STOP) && w_bit_end && w_rx_s;
      w_stop_bad = (r_state == ST_STOP) && w_bit_end && !w_rx_s;
   end

   // Bit timing counter, bit index and shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= 16'd0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
      end else begin
         case (r_state)
            ST_START:         r_cnt <= w_half_end ? 16'd0 : r_cnt + 16'd1;
            ST_DATA, ST_STOP: r_cnt <= w_bit_end  ? 16'd0 : r_cnt + 16'd1;
            default:          r_cnt <= 16'd0;
         endcase
         if (r_state == ST_IDLE) begin
            r_bit_idx <= 3'd0;
         end
         if (w_shift_en) begin
            r_shift   <= {w_rx_s, r_shift[7:1]};  // LSB first
            r_bit_idx <= r_bit_idx + 3'd1;
         end
      end
   end

   // Byte output and note decode stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_data    <= 8'd0;
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_nota       <= NOTA_DO;
         r_nota_valid <= 1'b0;
         r_nota_err   <= 1'b0;
      end else begin
         r_rx_valid  <= w_stop_ok;
         r_frame_err <= w_stop_bad;
         if (w_stop_ok) r_rx_data <= r_shift;
         // Decode the byte published in the previous cycle.
         r_nota_valid <= r_rx_valid && (r_rx_data[7:3] == 5'd0);
         r_nota_err   <= r_rx_valid && (r_rx_data[7:3] != 5'd0);
         if (r_rx_valid && (r_rx_data[7:3] == 5'd0)) r_nota <= r_rx_data[2:0];
      end
   end

   assign o_rx_data    = r_rx_data;
   assign o_rx_valid   = r_rx_valid;
   assign o_frame_err  = r_frame_err;
   assign o_busy       = w_busy;
   assign o_nota       = r_nota;
   assign o_nota_valid = r_nota_valid;
   assign o_nota_err   = r_nota_err;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_rx_nota.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_nota
// Directed + randomized bench for uart_rx_nota. Frames are generated at the
// bit level; expected bytes, event times and note results come from the
// frame arithmetic (t0 + half + 9 bits) and a byte-value rule (< 8 is a note).
// ---------------------------------------------------------------------------
module tb_uart_rx_nota;
   import uart_pkg::*;

   localparam int CLK_FREQ    = 25_000_000;
   localparam int BAUD        = 115_200;
   localparam int BIT         = CLK_FREQ / BAUD;
   localparam int HALF_BIT    = BIT / 2;
   localparam int STOP_SAMPLE = HALF_BIT + 9 * BIT;

   // clock / reset
   logic clk = 1'b0;
   logic rst;
   logic rx;
   always #20 clk = ~clk;

   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       o_frame_err;
   logic       o_busy;
   logic [2:0] o_nota;
   logic       o_nota_valid;
   logic       o_nota_err;
   logic [2:0] o_dbg_state;

   uart_rx_nota #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_rx         (rx),
      .o_rx_data    (o_rx_data),
      .o_rx_valid   (o_rx_valid),
      .o_frame_err  (o_frame_err),
      .o_busy       (o_busy),
      .o_nota       (o_nota),
      .o_nota_valid (o_nota_valid),
      .o_nota_err   (o_nota_err),
      .o_dbg_state  (o_dbg_state)
   );

   // cyc == n after the n-th rising edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor (samples on the falling edge)
   int         rxv_cyc_q[$];
   logic [7:0] rxv_data_q[$];
   int         ferr_cyc_q[$];
   int         nv_cyc_q[$];
   logic [2:0] nv_val_q[$];
   int         ne_cyc_q[$];
   int         excl_viol = 0;
   int         busy_rise = -1;
   int         busy_fall = -1;
   logic       prev_busy = 1'b0;

   always @(negedge clk) begin
      if (o_rx_valid) begin
         rxv_cyc_q.push_back(cyc);
         rxv_data_q.push_back(o_rx_data);
      end
      if (o_frame_err)  ferr_cyc_q.push_back(cyc);
      if (o_nota_valid) begin
         nv_cyc_q.push_back(cyc);
         nv_val_q.push_back(o_nota);
      end
      if (o_nota_err) ne_cyc_q.push_back(cyc);
      if ((o_rx_valid && o_frame_err) || (o_nota_valid && o_nota_err)) excl_viol++;
      if (o_busy && !prev_busy) busy_rise = cyc;
      if (!o_busy && prev_busy) busy_fall = cyc;
      prev_busy = o_busy;
   end

   // scoreboard
   logic [7:0] exp_q[$];
   logic [2:0] model_nota = 3'd0;
   logic [7:0] last_good  = 8'd0;
   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      rxv_cyc_q.delete();
      rxv_data_q.delete();
      ferr_cyc_q.delete();
      nv_cyc_q.delete();
      nv_val_q.delete();
      ne_cyc_q.delete();
   endtask

   // driver: one 8N1 frame, each bit held len clocks; returns t0
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int len,
                             output int t0);
      @(negedge clk);
      rx = 1'b0;
      t0 = cyc + 3;
      repeat (len) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         repeat (len) @(negedge clk);
      end
      rx = stop_bit;
      repeat (len) @(negedge clk);
      if (stop_bit) exp_q.push_back(b);
   endtask

   task automatic check_good(input string tag, input int t0);
      logic [7:0] exp_b;
      exp_b = exp_q.pop_front();
      chk({tag, " rx_valid count"}, rxv_cyc_q.size(), 1);
      chk({tag, " frame_err none"}, ferr_cyc_q.size(), 0);
      if (rxv_cyc_q.size() > 0) begin
         chk({tag, " rx_valid time"}, rxv_cyc_q[0], t0 + STOP_SAMPLE);
         chk({tag, " rx_data"}, {24'd0, rxv_data_q[0]}, {24'd0, exp_b});
      end
      if (exp_b < 8) begin
         model_nota = exp_b[2:0];
         chk({tag, " nota_valid count"}, nv_cyc_q.size(), 1);
         chk({tag, " nota_err none"}, ne_cyc_q.size(), 0);
         if (nv_cyc_q.size() > 0) begin
            chk({tag, " nota_valid time"}, nv_cyc_q[0], t0 + STOP_SAMPLE + 1);
            chk({tag, " nota value"}, {29'd0, nv_val_q[0]}, {29'd0, model_nota});
         end
      end else begin
         chk({tag, " nota_err count"}, ne_cyc_q.size(), 1);
         chk({tag, " nota_valid none"}, nv_cyc_q.size(), 0);
         if (ne_cyc_q.size() > 0)
            chk({tag, " nota_err time"}, ne_cyc_q[0], t0 + STOP_SAMPLE + 1);
      end
      chk({tag, " nota held"}, {29'd0, o_nota}, {29'd0, model_nota});
      last_good = exp_b;
      clear_mon();
   endtask

   initial begin
      int t0;
      int fall;
      logic [7:0] rb;
      int len;

      // reset
      rst = 1'b1;
      rx  = 1'b1;
      repeat (5) @(negedge clk);
      chk("reset rx_data",    {24'd0, o_rx_data}, 0);
      chk("reset rx_valid",   {31'd0, o_rx_valid}, 0);
      chk("reset frame_err",  {31'd0, o_frame_err}, 0);
      chk("reset busy",       {31'd0, o_busy}, 0);
      chk("reset nota",       {29'd0, o_nota}, 0);
      chk("reset nota_valid", {31'd0, o_nota_valid}, 0);
      chk("reset nota_err",   {31'd0, o_nota_err}, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // 0x02 at exact baud, with busy timing
      send_frame(8'h02, 1'b1, BIT, t0);
      chk("f02 busy rise", busy_rise, t0);
      chk("f02 busy fall", busy_fall, t0 + STOP_SAMPLE);
      check_good("f02", t0);

      // 0x35: not a note
      repeat (30) @(negedge clk);
      send_frame(8'h35, 1'b1, BIT, t0);
      check_good("f35", t0);

      // 50-cycle glitch: false start
      repeat (30) @(negedge clk);
      rx = 1'b0;
      fall = cyc;
      repeat (50) @(negedge clk);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch busy rise", busy_rise, fall + 3);
      chk("glitch busy fall", busy_fall, fall + 3 + HALF_BIT);
      chk("glitch busy low", {31'd0, o_busy}, 0);
      chk("glitch no pulses", rxv_cyc_q.size() + ferr_cyc_q.size() + nv_cyc_q.size()
                               + ne_cyc_q.size(), 0);

      // 0x04 with a 0 stop bit, then break held 3000 cycles
      send_frame(8'h04, 1'b0, BIT, t0);
      repeat (3000) @(negedge clk);
      chk("break frame_err count", ferr_cyc_q.size(), 1);
      if (ferr_cyc_q.size() > 0) chk("break frame_err time", ferr_cyc_q[0], t0 + STOP_SAMPLE);
      chk("break no rx_valid", rxv_cyc_q.size(), 0);
      chk("break rx_data held", {24'd0, o_rx_data}, {24'd0, last_good});
      chk("break busy high", {31'd0, o_busy}, 1);
      rx = 1'b1;
      fall = cyc;
      repeat (20) @(negedge clk);
      chk("break busy fall", busy_fall, fall + 3);
      chk("break single error", ferr_cyc_q.size(), 1);
      clear_mon();

      // back-to-back notes Do, Mi, Sol
      send_frame({5'd0, NOTA_DO}, 1'b1, BIT, t0);
      check_good("b2b0", t0);
      send_frame({5'd0, NOTA_MI}, 1'b1, BIT, t0);
      check_good("b2b1", t0);
      send_frame({5'd0, NOTA_SOL}, 1'b1, BIT, t0);
      check_good("b2b2", t0);

      // random bytes, baud off by up to about 2%
      for (int i = 0; i < 8; i++) begin
         rb  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
         len = BIT - 4 + 4 * int'($urandom_range(0, 2));
         repeat ($urandom_range(0, 40)) @(negedge clk);
         send_frame(rb, 1'b1, len, t0);
         check_good("rand", t0);
      end

      // known non-reset state before the mid-frame reset
      send_frame(8'h06, 1'b1, BIT, t0);
      check_good("f06", t0);

      // reset during data bit 4 of a frame
      rb = 8'hA5;
      @(negedge clk);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         rx = rb[k];
         repeat (BIT) @(negedge clk);
      end
      rx = rb[4];
      repeat (100) @(negedge clk);
      chk("pre-reset busy", {31'd0, o_busy}, 1);
      #7 rst = 1'b1;
      #1;
      chk("mid reset rx_data",    {24'd0, o_rx_data}, 0);
      chk("mid reset rx_valid",   {31'd0, o_rx_valid}, 0);
      chk("mid reset frame_err",  {31'd0, o_frame_err}, 0);
      chk("mid reset busy",       {31'd0, o_busy}, 0);
      chk("mid reset nota",       {29'd0, o_nota}, 0);
      chk("mid reset nota_valid", {31'd0, o_nota_valid}, 0);
      chk("mid reset nota_err",   {31'd0, o_nota_err}, 0);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_nota = 3'd0;
      last_good  = 8'd0;
      exp_q.delete();
      clear_mon();
      repeat (30) @(negedge clk);
      chk("post reset quiet", rxv_cyc_q.size() + ferr_cyc_q.size(), 0);
      send_frame(8'h03, 1'b1, BIT, t0);
      check_good("f03", t0);

      chk("mutual exclusion", excl_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_nota.md
# uart_rx_nota

UART receiver with a note decoder: the return path for the note bytes our FPGA transmitter emits at 115200 baud, 8N1, 25 MHz clock. It synchronizes the serial line, recovers frames by mid-bit sampling and flags framing errors. Valid bytes 0–7 become a 3-bit note index. It sits behind the board's RX pin and feeds the note/LED logic, and it is the loopback checker for the transmitter.

## Interface
- CLK_FREQ, 25_000_000, system clock in Hz
- BAUD_RATE, 115200, serial bit rate
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rx  in  1  raw serial line, idle high, asynchronous to clk
- rx_data  out  8  last correctly framed byte; reset 0x00
- rx_valid  out  1  one-cycle pulse when rx_data is updated; reset 0
- frame_err  out  1  one-cycle pulse when the stop bit samples 0; reset 0
- busy  out  1  high in any state other than IDLE; reset 0
- nota  out  3  last valid note index; reset 3'd0 (Do)
- nota_valid  out  1  one-cycle pulse, one cycle after rx_valid, when the byte is a note; reset 0
- nota_err  out  1  one-cycle pulse, one cycle after rx_valid, when rx_data[7:3] != 0; reset 0

## Operation
- BIT_TIME = CLK_FREQ/BAUD_RATE (integer division), giving 217. HALF = BIT_TIME/2, giving 108. Bit counter is 16 bits wide. Elaboration fails if BIT_TIME < 4.
- rx passes through a 2-FF synchronizer, preset to 1 on reset. The synchronizer output is rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rx_s = 0, go to START, counter = 0.
- START: counter increments. At counter = HALF-1, sample rx_s.
  - rx_s = 1: false start, go to IDLE.
  - rx_s = 0: go to DATA, counter = 0, bit index = 0.
- DATA: at counter = BIT_TIME-1, shift rx_s in LSB first and reset the counter. After bit index 7, go to STOP.
- STOP: at counter = BIT_TIME-1, sample rx_s.
  - rx_s = 1: load rx_data from the shift register, pulse rx_valid, go to IDLE.
  - rx_s = 0: pulse frame_err, leave rx_data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s = 1, then go to IDLE. A held-low break line yields exactly one frame_err.
- Note stage (registered, runs on the cycle after rx_valid):
  - rx_data[7:3] = 0: nota ← rx_data[2:0], pulse nota_valid.
  - Otherwise: pulse nota_err and hold nota.
- rx_valid and frame_err are mutually exclusive. nota_valid and nota_err are mutually exclusive.
- The next frame's start bit is accepted in the cycle right after STOP returns to IDLE. One stop bit back-to-back is sustained.
- Reset mid-frame: the FSM goes to IDLE immediately and every output takes its reset value. The partial frame is discarded. A line still low after reset release is treated as a new start bit.

## Timing
- t0 is the clock edge at which IDLE first sees rx_s = 0. This is the 3rd rising edge after the pin falls, with setup met.
- Samples:
  - Start bit: t0+HALF.
  - Data bit k: t0+HALF+(k+1)·BIT_TIME.
  - Stop bit: t0+HALF+9·BIT_TIME, which is t0+2061 at defaults.
- rx_valid or frame_err is high for the one cycle following the stop-sample edge.
- nota, nota_valid and nota_err change one cycle after that.
- busy rises the cycle after t0. It falls the cycle after the stop-sample edge, or on the exit from WAIT_IDLE.
- Tolerates ±2% baud mismatch: sampling drift across 9.5 bits stays under half a bit.

## Structure
- Shared uart_pkg (include/package) holds:
  - CLK_FREQ and BAUD_RATE defaults, and BIT_TIME and HALF derivations.
  - FSM state encodings.
  - Note constants NOTA_DO=0, NOTA_MI=2, NOTA_SOL=4, shared with the transmitter-side note mapping.
- One natural sub-module, sincronizador_2ff: 2 flops, with the reset value as a parameter. It is reused for other asynchronous inputs such as the sensor.
- The note decode stays inline; it is a single register stage.

## Test plan
- Send 0x02, 8N1, at exact baud:
  - rx_data=0x02, with one rx_valid pulse at t0+2061.
  - nota=2 and nota_valid on the next cycle; no errors.
- Send 0x35: rx_valid with rx_data=0x35, then nota_err pulses and nota keeps its previous value.
- Glitch rx low for 50 cycles in IDLE: false start, back to IDLE by t0+108, no pulses, busy low again.
- Frame 0x04 with stop bit 0, then hold low 3000 cycles:
  - One frame_err pulse, rx_data unchanged, busy high until the line returns high.
  - No second error.
- Loop back from the transmitter with 0x00, 0x02, 0x04 back-to-back: three rx_valid pulses, nota sequence 0→2→4, no frame_err.
- Assert rst at bit 4 of a frame:
  - All outputs return to reset values within that cycle.
  - The next clean frame 0x03 is received correctly.
